out_fsm: RTL and testbench



---
 rtl/out_fsm.sv | 131 +++++++++++++
 tb/tb_out_fsm.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_fsm.sv
// UM Output instruction: reads register C, range-checks it and sends the low byte
// to the console over a valid/ready handshake, then reports finished/fault.
package out_fsm_pkg;
    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] data;
        logic        mode;
    } reg_in_bus_t;
endpackage

module out_fsm
    import out_fsm_pkg::*;
#(
    parameter int unsigned TX_TIMEOUT = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  regC,
    input  logic [31:0] reg_data_out,
    output reg_in_bus_t reg_in,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        finished,
    output logic        fault
);

    typedef enum logic [2:0] {
        READ,
        CAPTURE,
        SEND,
        DONE,
        FAULT
    } state_t;

    // Counter value on the last SEND cycle allowed before a timeout fault.
    localparam logic [CNT_W-1:0] TO_LAST =
        (TX_TIMEOUT == 0) ? '0 : CNT_W'(TX_TIMEOUT - 1);

    state_t           state, state_n;
    logic [2:0]       sel_q, sel_q_n;
    logic [31:0]      val_q, val_q_n;
    logic [7:0]       data_q, data_n;
    logic             valid_q, valid_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= READ;
            sel_q   <= '0;
            val_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_n;
            sel_q   <= sel_q_n;
            val_q   <= val_q_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            cnt_q   <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        sel_q_n  = sel_q;
        val_q_n  = val_q;
        data_n   = data_q;
        valid_n  = valid_q;
        cnt_n    = cnt_q;
        reg_in   = '0;
        finished = 1'b0;
        fault    = 1'b0;

        case (state)
            READ: begin
                reg_in.sel = regC;
                sel_q_n    = regC;
                valid_n    = 1'b0;
                state_n    = CAPTURE;
            end
            CAPTURE: begin
                reg_in.sel = sel_q;
                val_q_n    = reg_data_out;
                cnt_n      = '0;
                if (|reg_data_out[31:8]) begin
                    valid_n = 1'b0;
                    state_n = FAULT;
                end else begin
                    data_n  = reg_data_out[7:0];
                    valid_n = 1'b1;
                    state_n = SEND;
                end
            end
            SEND: begin
                // A ready on the final allowed cycle still wins over the timeout.
                if (valid_q && tx_ready) begin
                    valid_n = 1'b0;
                    cnt_n   = '0;
                    state_n = DONE;
                end else if (TX_TIMEOUT != 0) begin
                    if (cnt_q == TO_LAST) begin
                        valid_n = 1'b0;
                        state_n = FAULT;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                finished = 1'b1;
                valid_n  = 1'b0;
            end
            FAULT: begin
                finished = 1'b1;
                fault    = 1'b1;
                valid_n  = 1'b0;
            end
            default: begin
                valid_n = 1'b0;
                state_n = READ;
            end
        endcase
    end

    assign tx_valid = valid_q;
    assign tx_data  = data_q;

endmodule

// File: tb/tb_out_fsm.sv
// Scoreboard bench for out_fsm: one instance without and one with a TX timeout.
module tb_out_fsm;
    import out_fsm_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] regs [8];
    logic        rst0, rst1, rdy0, rdy1;
    logic [2:0]  c0, c1;
    reg_in_bus_t ri0, ri1;
    logic [31:0] rd0, rd1;
    logic [7:0]  td0, td1;
    logic        tv0, tv1, fin0, fin1, flt0, flt1;

    assign rd0 = regs[ri0.sel];
    assign rd1 = regs[ri1.sel];

    out_fsm #(.TX_TIMEOUT(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(rst0), .regC(c0), .reg_data_out(rd0), .reg_in(ri0),
        .tx_data(td0), .tx_valid(tv0), .tx_ready(rdy0), .finished(fin0), .fault(flt0)
    );

    out_fsm #(.TX_TIMEOUT(4), .CNT_W(16)) dut1 (
        .clk(clk), .reset(rst1), .regC(c1), .reg_data_out(rd1), .reg_in(ri1),
        .tx_data(td1), .tx_valid(tv1), .tx_ready(rdy1), .finished(fin1), .fault(flt1)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit         done;
        logic [7:0] data;
        bit         flt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_note(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    function automatic exp_t ebyte(input logic [7:0] d);
        exp_t e;
        e.done = 1'b0; e.data = d; e.flt = 1'b0;
        return e;
    endfunction

    function automatic exp_t edone(input bit f);
        exp_t e;
        e.done = 1'b1; e.data = '0; e.flt = f;
        return e;
    endfunction

    // Monitors: compare every byte on offer and every completion against the queues.
    logic fin0_d = 1'b0;
    logic fin1_d = 1'b0;

    always @(negedge clk) begin
        check("reg_in0_mode", {31'b0, ri0.mode}, 32'h0);
        check("reg_in0_data", ri0.data, 32'h0);
        if (tv0) begin
            if (q0.size() == 0 || q0[0].done) begin
                if (rdy0) fail_note("unexpected_tx0");
            end else begin
                check("tx_data0", {24'b0, td0}, {24'b0, q0[0].data});
                if (rdy0) void'(q0.pop_front());
            end
        end
        if (fin0 && !fin0_d) begin
            if (q0.size() == 0 || !q0[0].done) fail_note("unexpected_finished0");
            else begin
                check("fault0", {31'b0, flt0}, {31'b0, q0[0].flt});
                void'(q0.pop_front());
            end
        end
        fin0_d <= fin0;
    end

    always @(negedge clk) begin
        check("reg_in1_mode", {31'b0, ri1.mode}, 32'h0);
        if (tv1) begin
            if (q1.size() == 0 || q1[0].done) begin
                if (rdy1) fail_note("unexpected_tx1");
            end else begin
                check("tx_data1", {24'b0, td1}, {24'b0, q1[0].data});
                if (rdy1) void'(q1.pop_front());
            end
        end
        if (fin1 && !fin1_d) begin
            if (q1.size() == 0 || !q1[0].done) fail_note("unexpected_finished1");
            else begin
                check("fault1", {31'b0, flt1}, {31'b0, q1[0].flt});
                void'(q1.pop_front());
            end
        end
        fin1_d <= fin1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fin0(input int budget);
        int k;
        k = 0;
        while (!fin0 && k < budget) begin
            tick();
            k++;
        end
        if (!fin0) fail_note("wait_fin0_timeout");
        tick();
    endtask

    task automatic reset0();
        rst0 = 1'b1;
        tick();
        tick();
    endtask

    task automatic reset1();
        rst1 = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        int n;
        logic [31:0] vals [4];
        bit          vflt [4];

        for (int i = 0; i < 8; i++) regs[i] = '0;
        rst0 = 1'b1; rst1 = 1'b1;
        c0 = 3'd3; c1 = 3'd0;
        rdy0 = 1'b1; rdy1 = 1'b0;
        tick(); tick(); tick();

        // Reset state
        check("rst_tx_valid", {31'b0, tv0}, 0);
        check("rst_tx_data", {24'b0, td0}, 0);
        check("rst_finished", {31'b0, fin0}, 0);
        check("rst_fault", {31'b0, flt0}, 0);
        check("rst_sel", {29'b0, ri0.sel}, 3);

        // Basic transfer latency
        regs[3] = 32'h41;
        q0.push_back(ebyte(8'h41));
        q0.push_back(edone(1'b0));
        rst0 = 1'b0;
        check("c0_tx_valid", {31'b0, tv0}, 0);
        check("c0_sel", {29'b0, ri0.sel}, 3);
        tick();
        check("c1_tx_valid", {31'b0, tv0}, 0);
        tick();
        check("c2_tx_valid", {31'b0, tv0}, 1);
        check("c2_tx_data", {24'b0, td0}, 32'h41);
        tick();
        check("c3_finished", {31'b0, fin0}, 1);
        check("c3_fault", {31'b0, flt0}, 0);
        check("c3_tx_valid", {31'b0, tv0}, 0);

        // Back-pressure, no timeout
        reset0();
        regs[5] = 32'h7A; c0 = 3'd5; rdy0 = 1'b0;
        q0.push_back(ebyte(8'h7A));
        q0.push_back(edone(1'b0));
        rst0 = 1'b0;
        tick(); tick();
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (tv0) n++;
            tick();
        end
        rdy0 = 1'b1;
        if (tv0) n++;
        tick();
        check("bp_valid_cycles", n, 6);
        check("bp_finished", {31'b0, fin0}, 1);

        // Range boundaries
        vals[0] = 32'h100;      vflt[0] = 1'b1;
        vals[1] = 32'hFFFFFFFF; vflt[1] = 1'b1;
        vals[2] = 32'hFF;       vflt[2] = 1'b0;
        vals[3] = 32'h00;       vflt[3] = 1'b0;
        for (int v = 0; v < 4; v++) begin
            reset0();
            regs[2] = vals[v]; c0 = 3'd2; rdy0 = 1'b1;
            if (!vflt[v]) q0.push_back(ebyte(vals[v][7:0]));
            q0.push_back(edone(vflt[v]));
            rst0 = 1'b0;
            tick(); tick();
            if (vflt[v]) begin
                check("rng_fault", {31'b0, flt0}, 1);
                check("rng_finished", {31'b0, fin0}, 1);
                check("rng_tx_valid", {31'b0, tv0}, 0);
                tick();
            end else begin
                check("rng_tx_valid", {31'b0, tv0}, 1);
                wait_fin0(10);
                check("rng_fault", {31'b0, flt0}, 0);
            end
        end

        // Timeout on the TX_TIMEOUT=4 instance
        regs[4] = 32'h33; c1 = 3'd4; rdy1 = 1'b0;
        q1.push_back(edone(1'b1));
        rst1 = 1'b0;
        tick(); tick();
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (tv1) n++;
            tick();
        end
        check("to_valid_cycles", n, 4);
        check("to_finished", {31'b0, fin1}, 1);
        check("to_fault", {31'b0, flt1}, 1);

        // Ready arriving on the final SEND cycle
        reset1();
        q1.push_back(ebyte(8'h33));
        q1.push_back(edone(1'b0));
        rst1 = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        check("to_last_valid", {31'b0, tv1}, 1);
        rdy1 = 1'b1;
        tick();
        check("to_last_finished", {31'b0, fin1}, 1);
        check("to_last_fault", {31'b0, flt1}, 0);

        // Reset during the second SEND cycle, then re-execute
        reset0();
        regs[1] = 32'h55; c0 = 3'd1; rdy0 = 1'b0;
        rst0 = 1'b0;
        tick(); tick(); tick();
        check("mid_valid_before", {31'b0, tv0}, 1);
        rst0 = 1'b1;
        tick();
        check("mid_valid_after", {31'b0, tv0}, 0);
        check("mid_finished", {31'b0, fin0}, 0);
        regs[1] = 32'h42;
        q0.push_back(ebyte(8'h42));
        q0.push_back(edone(1'b0));
        rdy0 = 1'b1;
        tick();
        rst0 = 1'b0;
        wait_fin0(10);

        // regC change during CAPTURE is ignored
        reset0();
        regs[1] = 32'h10; regs[6] = 32'h20; c0 = 3'd1; rdy0 = 1'b1;
        q0.push_back(ebyte(8'h10));
        q0.push_back(edone(1'b0));
        rst0 = 1'b0;
        tick();
        c0 = 3'd6;
        #1;
        check("cap_sel", {29'b0, ri0.sel}, 1);
        check("cap_rd", rd0, 32'h10);
        wait_fin0(10);

        tick(); tick();
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
